ex_iter_div: RTL and testbench
==============================

// Module: ex_iter_div
// PURPOSE
// - Parametrised iterative integer divider for the EX stage; replaces the vendor divider IP pair with one RTL unit.
// - Handles signed and unsigned operands, returns quotient and remainder together, carries a tag, and is cancelled by pipeline flush.
// - EX issues on in_valid/in_ready and stalls readygo until out_valid; MEM-side backpressure arrives via out_ready.
// PARAMETERS
// - WIDTH  32  operand/result width in bits (>=4)
// - TAG_W  5   width of the opaque tag (e.g. rf_waddr) returned with the result
// PORTS
// - clk          in   1        clock; single clock domain
// - rst          in   1        reset, synchronous, active-high
// - flush        in   1        pipeline flush (exception/ertn); cancels any operation
// - in_valid     in   1        request valid
// - in_ready     out  1        request accepted when in_valid & in_ready
// - in_signed    in   1        1: two's-complement operands; 0: unsigned
// - in_dividend  in   WIDTH    dividend
// - in_divisor   in   WIDTH    divisor
// - in_tag       in   TAG_W    tag, returned unchanged
// - out_valid    out  1        result valid; held until out_ready
// - out_ready    in   1        consumer accepts result
// - out_quot     out  WIDTH    quotient
// - out_rem      out  WIDTH    remainder
// - out_tag      out  TAG_W    tag of the result
// - busy         out  1        operation in flight (state != IDLE)
// BEHAVIOUR
// - States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
// - IDLE: in_ready=1; accept latches operands, sign flag, tag; -> PREP.
// - PREP (1 cyc): take magnitudes (signed mode), record q_neg = sign(a)^sign(b), r_neg = sign(a); clear iteration counter; -> CALC.
// - CALC: one restoring step per cycle (shift-in dividend bit, trial subtract of |divisor|, set quotient bit); WIDTH cycles; counter wraps to 0 on the last step -> FIX.
// - FIX (1 cyc): negate quotient if q_neg, remainder if r_neg; -> DONE.
// - DONE: out_valid=1; outputs stable until out_ready. On out_ready -> IDLE.
// - in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back issue with no bubble.
// - Latency: accepted at cycle T -> out_valid first high at T+WIDTH+3.
// - Rounding: quotient truncates toward zero; remainder takes the dividend's sign; |rem| < |divisor|.
// - Signed overflow (-2^(WIDTH-1) / -1): quot = -2^(WIDTH-1), rem = 0.
// - Divisor zero (both modes): quot = all ones, rem = dividend (raw input value); no exception raised.
// - Internal arithmetic on WIDTH+1 bits so the most-negative magnitude is exact.
// - flush: any state -> IDLE next cycle, out_valid drops next cycle, result discarded; in_valid in a flush cycle is not accepted; flush overrides out_ready.
// - rst: same as flush; resets all registers.
// - Reset values: in_ready=1, out_valid=0, busy=0, out_quot=0, out_rem=0, out_tag=0.
// CONFIGURATION
// - DIV_ZERO_FAST_EN defined: PREP detects divisor==0 and goes straight to DONE with the zero-divisor result; latency T+2.
// - Not defined: divisor zero runs the full WIDTH+3 cycles; FIX forces the zero-divisor result. Values identical either way.
// STRUCTURE
// - Package ex_div_pkg: state enum (IDLE, PREP, CALC, FIX, DONE); localparam for counter width $clog2(WIDTH) as a function; zero-divisor result constants.
// - Sub-module div_step (combinational): {rem_in, q_in, divisor} -> {rem_out, q_out}, one restoring iteration; instantiated once.
// - Top: FSM, operand/sign registers, counter, output registers.
// TESTING (WIDTH=32)
// - Unsigned 100/7 -> quot=14, rem=2, out_valid at T+35, out_tag echoed.
// - Signed -7/2 -> quot=-3 (0xFFFFFFFD), rem=-1 (0xFFFFFFFF); 7/-2 -> quot=-3, rem=1.
// - Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned same operands -> quot=0, rem=0x80000000.
// - Divisor 0, dividend 0x1234 -> quot=0xFFFFFFFF, rem=0x1234; latency T+2 with DIV_ZERO_FAST_EN, T+35 without.
// - flush at CALC cycle 10 -> busy=0 and in_ready=1 next cycle, no out_valid; next op 9/3 -> quot=3, rem=0.
// - out_ready low 5 cycles in DONE -> outputs held; out_ready & in_valid same cycle -> new op accepted, no bubble.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package ex_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Iteration counter width; at least one bit even for degenerate widths.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Divide by zero: quotient is all ones, remainder is the raw dividend.
    localparam logic DZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract, set quotient bit.
module div_step
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Trial value needs WIDTH+1 bits; after a successful subtract it fits WIDTH again.
    assign w_trial = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, i_dvs});
    assign w_diff  = w_trial[WIDTH-1:0] - i_dvs;
    assign o_rem   = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/ex_iter_div.sv
// Iterative signed/unsigned divider for EX, one quotient bit per cycle, flushable.
// DIV_ZERO_FAST_EN: short-circuit a zero divisor from PREP straight to DONE.
module ex_iter_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       r_state, w_state_nxt;
    logic             r_signed, r_q_neg, r_r_neg, r_dz;
    logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo, r_dvs;
    logic [WIDTH-1:0] r_out_quot, r_out_rem;
    logic [TAG_W-1:0] r_tag, r_out_tag;
    logic [CW-1:0]    r_cnt;

    logic             w_accept, w_dz, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_nxt, w_quo_nxt;

    assign w_accept = in_valid & in_ready & ~flush;
    assign w_dz     = (r_b == '0);
    assign w_a_neg  = r_signed & r_a[WIDTH-1];
    assign w_b_neg  = r_signed & r_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = PREP;
            PREP: begin
`ifdef DIV_ZERO_FAST_EN
                w_state_nxt = w_dz ? DONE : CALC;
`else
                w_state_nxt = CALC;
`endif
            end
            CALC: if (r_cnt == LAST) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = w_accept ? PREP : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_comb begin
        in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_dz       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_out_quot <= '0;
            r_out_rem  <= '0;
            r_out_tag  <= '0;
        end else begin
            if (w_accept) begin
                r_signed <= in_signed;
                r_a      <= in_dividend;
                r_b      <= in_divisor;
                r_tag    <= in_tag;
            end
            unique case (r_state)
                PREP: begin
                    r_rem   <= '0;
                    r_quo   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_cnt   <= '0;
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_dz    <= w_dz;
`ifdef DIV_ZERO_FAST_EN
                    if (w_dz) begin
                        r_out_quot <= {WIDTH{DZ_QUOT_BIT}};
                        r_out_rem  <= r_a;
                        r_out_tag  <= r_tag;
                    end
`endif
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                end
                FIX: begin
                    // Zero divisor reports the raw dividend, not the magnitude path result.
                    if (r_dz) begin
                        r_out_quot <= {WIDTH{DZ_QUOT_BIT}};
                        r_out_rem  <= r_a;
                    end else begin
                        r_out_quot <= r_q_neg ? -r_quo : r_quo;
                        r_out_rem  <= r_r_neg ? -r_rem : r_rem;
                    end
                    r_out_tag <= r_tag;
                end
                default: ;
            endcase
        end
    end

    assign out_quot = r_out_quot;
    assign out_rem  = r_out_rem;
    assign out_tag  = r_out_tag;

endmodule

// File: tb/tb_ex_iter_div.sv
// Directed bench for ex_iter_div (WIDTH=32): values, latency, flush, backpressure.
module tb_ex_iter_div;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = WIDTH + 3;
`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = WIDTH + 3;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, in_signed;
    logic [WIDTH-1:0] in_dividend, in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, busy;
    logic [WIDTH-1:0] out_quot, out_rem;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_iter_div #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_tag     (out_tag),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns just after the accepting edge.
    task automatic issue(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tag);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
        in_valid    = 1'b1;
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles from the accepting edge until out_valid, then check the result.
    task automatic wait_res(input string nm, input int lat, input logic [WIDTH-1:0] q,
                            input logic [WIDTH-1:0] r, input logic [TAG_W-1:0] tag, input bit rel);
        int cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            chk({nm, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk({nm, "_quot"}, 64'(out_quot), 64'(q));
        chk({nm, "_rem"}, 64'(out_rem), 64'(r));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_dividend = '0; in_divisor = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_quot", 64'(out_quot), 64'd0);
        chk("rst_rem", 64'(out_rem), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);

        issue(1'b0, 32'd100, 32'd7, 5'd5);
        wait_res("u100_7", LAT, 32'd14, 32'd2, 5'd5, 1'b1);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd1);
        wait_res("s_m7_2", LAT, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'd1, 1'b1);

        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd2);
        wait_res("s_7_m2", LAT, 32'hFFFF_FFFD, 32'd1, 5'd2, 1'b1);

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        wait_res("s_ovf", LAT, 32'h8000_0000, 32'd0, 5'd3, 1'b1);

        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        wait_res("u_big", LAT, 32'd0, 32'h8000_0000, 5'd4, 1'b1);

        issue(1'b0, 32'h0000_1234, 32'd0, 5'd6);
        wait_res("u_dz", DZ_LAT, 32'hFFFF_FFFF, 32'h0000_1234, 5'd6, 1'b1);

        issue(1'b1, 32'hFFFF_FF00, 32'd0, 5'd8);
        wait_res("s_dz_neg", DZ_LAT, 32'hFFFF_FFFF, 32'hFFFF_FF00, 5'd8, 1'b1);

        // Flush in the tenth CALC cycle.
        issue(1'b0, 32'd1000, 32'd3, 5'd7);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // A request coinciding with flush must be dropped.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_dividend = 32'd5; in_divisor = 32'd1; in_tag = 5'd11;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        chk("flush_blocks_accept", 64'(busy), 64'd0);

        issue(1'b0, 32'd9, 32'd3, 5'd2);
        wait_res("after_flush", LAT, 32'd3, 32'd0, 5'd2, 1'b1);

        // Backpressure: hold DONE for five cycles, then release with a new request.
        issue(1'b0, 32'd50, 32'd5, 5'd3);
        wait_res("bp", LAT, 32'd10, 32'd0, 5'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_quot", 64'(out_quot), 64'd10);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0;
        in_dividend = 32'd20; in_divisor = 32'd6; in_tag = 5'd9;
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_out_valid", 64'(out_valid), 64'd0);
        chk("b2b_in_ready", 64'(in_ready), 64'd0);
        wait_res("b2b", LAT, 32'd3, 32'd2, 5'd9, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
